// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for a 4-to-16 one-hot decoder: steps through the set bits of a latched
// channel mask, holding each index for dwell+1 cycles, in single-shot or looping mode.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single_shot,
    input  logic [15:0]        chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         hex_out,
    output logic               en_out,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e               r_state, w_state_nxt;
    logic [15:0]          r_mask, w_mask_nxt;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]           r_hex, w_hex_nxt;
    logic                 r_en, w_en_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_wrap, w_wrap_nxt;
    logic                 r_done, w_done_nxt;

    logic [15:0]          w_upper;
    logic                 w_has_upper;
    logic [3:0]           w_next_upper;
    logic [3:0]           w_first_latched;
    logic [3:0]           w_first_in;
    logic                 w_dwell_end;

    function automatic logic [3:0] f_lowest(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Channels strictly above the current index; empty means the next step wraps.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < 16; i++) begin
            w_upper[i] = r_mask[i] && (4'(i) > r_hex);
        end
    end

    assign w_has_upper     = |w_upper;
    assign w_next_upper    = f_lowest(w_upper);
    assign w_first_latched = f_lowest(r_mask);
    assign w_first_in      = f_lowest(chan_mask);
    assign w_dwell_end     = (r_cnt == r_dwell);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_hex_nxt   = r_hex;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start && !stop && (chan_mask != '0)) begin
                    w_state_nxt = StScan;
                    w_mask_nxt  = chan_mask;
                    w_dwell_nxt = dwell;
                    w_cnt_nxt   = '0;
                    w_hex_nxt   = w_first_in;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            StScan: begin
                if (stop) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_hex_nxt   = '0;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_dwell_end) begin
                    // Counter resets here, so it never runs past the dwell compare.
                    w_cnt_nxt = '0;
                    if (w_has_upper) begin
                        w_hex_nxt = w_next_upper;
                    end else if (single_shot) begin
                        w_state_nxt = StIdle;
                        w_hex_nxt   = '0;
                        w_en_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_hex_nxt  = w_first_latched;
                        w_wrap_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_mask  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_hex   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hex   <= w_hex_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign hex_out = r_hex;
    assign en_out  = r_en;
    assign busy    = r_busy;
    assign wrap    = r_wrap;
    assign done    = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: per-cycle vector table plus hand sequences for
// async reset, maximum dwell and randomly masked single-shot passes.
module tb_decoder_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        single_shot = 1'b0;
    logic [15:0] chan_mask = '0;
    logic [7:0]  dwell = '0;
    logic [3:0]  hex_out;
    logic        en_out;
    logic        busy;
    logic        wrap;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .single_shot(single_shot),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .hex_out    (hex_out),
        .en_out     (en_out),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        ss;
        logic [15:0] mask;
        logic [7:0]  dwell;
        logic [3:0]  hex;
        logic        en;
        logic        busy;
        logic        wrap;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic ss, input logic [15:0] m,
                       input logic [7:0] d, input logic [3:0] h, input logic e,
                       input logic b, input logic w, input logic dn);
        vec_t v;
        v.start = st; v.stop = sp; v.ss = ss; v.mask = m; v.dwell = d;
        v.hex = h; v.en = e; v.busy = b; v.wrap = w; v.done = dn;
        vecs.push_back(v);
    endtask

    // Observed outputs packed as {hex, en, busy, wrap, done}.
    function automatic logic [7:0] obs();
        return {hex_out, en_out, busy, wrap, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n;
        logic [15:0] rm;
        logic [7:0]  rd;
        logic [7:0]  exp_o;

        // Test 1: three-channel single-shot pass.
        add(1, 0, 1, 16'h0025, 1, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 2, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 2, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 5, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 5, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 16'h0025, 1, 0, 0, 0, 0, 0);
        // Test 2: loop mode with wrap pulses; stop at a wrap point suppresses wrap.
        add(1, 0, 0, 16'h8001, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 16'h8001, 0, 15, 1, 1, 0, 0);
        add(0, 0, 0, 16'h8001, 0, 0,  1, 1, 1, 0);
        add(0, 0, 0, 16'h8001, 0, 15, 1, 1, 0, 0);
        add(0, 0, 0, 16'h8001, 0, 0,  1, 1, 1, 0);
        add(0, 0, 0, 16'h8001, 0, 15, 1, 1, 0, 0);
        add(0, 1, 0, 16'h8001, 0, 0,  0, 0, 0, 0);
        // Test 3: stop on 2nd cycle of channel 2, then restart from channel 0.
        add(1, 0, 1, 16'h0025, 3, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 3, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 3, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 3, 0, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 3, 2, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0025, 3, 2, 1, 1, 0, 0);
        add(0, 1, 1, 16'h0025, 3, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0025, 3, 0, 1, 1, 0, 0);
        add(0, 1, 1, 16'h0025, 3, 0, 0, 0, 0, 0);
        // Test 4: empty-mask start, start+stop, start mid-scan with a new mask.
        add(1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 16'h0025, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0025, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 16'h0F00, 0, 2, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0F00, 0, 5, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0F00, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0);
        // Test 5: single-bit mask loops on itself, wrap every dwell+1 cycles.
        add(1, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 1, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 1, 0);
        add(0, 0, 0, 16'h0010, 3, 4, 1, 1, 0, 0);

        #1;
        chk("reset_outputs", 32'(obs()), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            stop = vecs[i].stop;
            single_shot = vecs[i].ss;
            chan_mask = vecs[i].mask;
            dwell = vecs[i].dwell;
            tick();
            exp_o = {vecs[i].hex, vecs[i].en, vecs[i].busy, vecs[i].wrap, vecs[i].done};
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(exp_o));
        end

        // Async reset in the middle of a dwell: outputs clear without a clock edge.
        @(negedge clk);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", 32'(obs()), 32'h0);
        tick();
        chk("async_reset_held", 32'(obs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("no_resume", 32'(obs()), 32'h0);

        // Maximum dwell: channel 0 held for exactly 256 cycles, then channel 1.
        @(negedge clk);
        start = 1'b1; single_shot = 1'b1; chan_mask = 16'h0003; dwell = 8'hFF;
        tick();
        start = 1'b0;
        n = 0;
        while (hex_out == 4'd0 && en_out && n < 400) begin
            n++;
            tick();
        end
        chk("dwell_max_len", 32'(n), 32'd256);
        chk("dwell_max_next", 32'(obs()), 32'({4'd1, 4'b1100}));
        @(negedge clk);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("dwell_max_stop", 32'(obs()), 32'h0);

        // Random single-shot passes against an ascending-channel model.
        for (int r = 0; r < 6; r++) begin
            rm = 16'($urandom_range(1, 65535));
            rd = 8'($urandom_range(0, 4));
            @(negedge clk);
            start = 1'b1; single_shot = 1'b1; chan_mask = rm; dwell = rd;
            @(posedge clk);
            #1;
            start = 1'b0;
            chan_mask = 16'($urandom());
            for (int c = 0; c < 16; c++) begin
                if (rm[c]) begin
                    for (int k = 0; k <= int'(rd); k++) begin
                        chk($sformatf("rnd%0d_ch%0d_k%0d", r, c, k), 32'(obs()),
                            32'({4'(c), 4'b1100}));
                        chk($sformatf("rnd%0d_en_mask", r),
                            32'(en_out && !rm[hex_out]), 32'd0);
                        tick();
                    end
                end
            end
            chk($sformatf("rnd%0d_done", r), 32'(obs()), 32'h1);
            chk($sformatf("rnd%0d_excl", r), 32'(wrap && done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
